// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: opcodes,
// R-type funct codes, ALU control codes, FSM states and instruction classes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_R    = 3'd0,
        C_ADDI = 3'd1,
        C_LW   = 3'd2,
        C_SW   = 3'd3,
        C_BAD  = 3'd4
    } iclass_t;

    function automatic iclass_t classify(input logic [5:0] op);
        iclass_t c;
        case (op)
            OP_R:    c = C_R;
            OP_ADDI: c = C_ADDI;
            OP_LW:   c = C_LW;
            OP_SW:   c = C_SW;
            default: c = C_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from instruction class and funct to ALU control code
// and a legality flag; unknown opcodes and R-type functs are illegal.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  iclass_t    iclass,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       legal
);

    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b0;
        case (iclass)
            C_R: begin
                legal = 1'b1;
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: legal = 1'b0;
                endcase
            end
            C_ADDI, C_LW, C_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: latches one instruction per handshake, sequences
// DECODE/EXEC/MEM/WB, drives datapath selects and counts retirements.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_instr_valid,
    input  logic [31:0] i_instruction,
    output logic        o_instr_ready,
    output logic [4:0]  o_first5bits,
    output logic [4:0]  o_second5bits,
    output logic [15:0] o_immediate,
    output logic        o_regDst,
    output logic        o_AluSource,
    output logic        o_MemToReg,
    output logic        o_RFSource,
    output logic        o_DMSource,
    output logic        o_DMValue,
    output logic [2:0]  o_AluControl,
    output logic        o_ReadWriteRF,
    output logic        o_WriteEnDataMemory,
    output logic        o_ReadEnDataMemory,
    output logic        o_illegal,
    output logic        o_retired,
    output logic [15:0] o_instr_count
);

    state_t      state, next_state;
    logic [31:0] ir;
    logic [15:0] instr_count;
    iclass_t     iclass;
    logic [2:0]  dec_alu;
    logic        legal;
    logic        active;

    assign iclass = classify(ir[31:26]);

    alu_decoder u_alu_decoder (
        .iclass      (iclass),
        .funct       (ir[5:0]),
        .alu_control (dec_alu),
        .legal       (legal)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && i_instr_valid)
                ir <= i_instruction;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            instr_count <= '0;
        else if (o_retired)
            instr_count <= instr_count + 16'd1;
    end

    assign o_instr_count = instr_count;
    assign o_first5bits  = ir[25:21];
    assign o_second5bits = ir[20:16];
    assign o_immediate   = ir[15:0];
    assign o_RFSource    = 1'b0;
    assign o_DMSource    = 1'b0;
    assign o_DMValue     = 1'b0;

    // Outside IDLE the IR only ever holds a legal instruction except in the
    // DECODE cycle of an illegal one, so legality gates the selects.
    assign active = (state != S_IDLE) && legal;

    always_comb begin
        next_state          = state;
        o_instr_ready       = 1'b0;
        o_illegal           = 1'b0;
        o_retired           = 1'b0;
        o_ReadWriteRF       = 1'b0;
        o_WriteEnDataMemory = 1'b0;
        o_ReadEnDataMemory  = 1'b0;
        o_regDst            = 1'b0;
        o_AluSource         = 1'b0;
        o_MemToReg          = 1'b0;
        o_AluControl        = ALU_ADD;

        case (state)
            S_IDLE: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                if (!legal) begin
                    o_illegal  = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                next_state = (iclass == C_LW || iclass == C_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                o_ReadEnDataMemory  = (iclass == C_LW);
                o_WriteEnDataMemory = (iclass == C_SW);
                if (iclass == C_SW) begin
                    o_retired  = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_state = S_WB;
                end
            end
            S_WB: begin
                o_ReadWriteRF      = 1'b1;
                o_ReadEnDataMemory = (iclass == C_LW);
                o_retired          = 1'b1;
                next_state         = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase

        if (active) begin
            o_AluControl = dec_alu;
            case (iclass)
                C_R: begin
                    o_regDst   = 1'b1;
                    o_MemToReg = 1'b1;
                end
                C_ADDI: begin
                    o_AluSource = 1'b1;
                    o_MemToReg  = 1'b1;
                end
                C_LW:    o_AluSource = 1'b1;
                C_SW:    o_AluSource = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_instr_valid = 1'b0;
    logic [31:0] i_instruction = '0;
    logic        o_instr_ready;
    logic [4:0]  o_first5bits, o_second5bits;
    logic [15:0] o_immediate;
    logic        o_regDst, o_AluSource, o_MemToReg, o_RFSource, o_DMSource, o_DMValue;
    logic [2:0]  o_AluControl;
    logic        o_ReadWriteRF, o_WriteEnDataMemory, o_ReadEnDataMemory;
    logic        o_illegal, o_retired;
    logic [15:0] o_instr_count;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_count = '0;

    // {ReadWriteRF, WriteEnDataMemory, ReadEnDataMemory}
    logic [2:0] strb;
    // {regDst, AluSource, MemToReg, RFSource, DMSource, DMValue}
    logic [5:0] sels;
    assign strb = {o_ReadWriteRF, o_WriteEnDataMemory, o_ReadEnDataMemory};
    assign sels = {o_regDst, o_AluSource, o_MemToReg, o_RFSource, o_DMSource, o_DMValue};

    multicycle_control dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_instr_valid       (i_instr_valid),
        .i_instruction       (i_instruction),
        .o_instr_ready       (o_instr_ready),
        .o_first5bits        (o_first5bits),
        .o_second5bits       (o_second5bits),
        .o_immediate         (o_immediate),
        .o_regDst            (o_regDst),
        .o_AluSource         (o_AluSource),
        .o_MemToReg          (o_MemToReg),
        .o_RFSource          (o_RFSource),
        .o_DMSource          (o_DMSource),
        .o_DMValue           (o_DMValue),
        .o_AluControl        (o_AluControl),
        .o_ReadWriteRF       (o_ReadWriteRF),
        .o_WriteEnDataMemory (o_WriteEnDataMemory),
        .o_ReadEnDataMemory  (o_ReadEnDataMemory),
        .o_illegal           (o_illegal),
        .o_retired           (o_retired),
        .o_instr_count       (o_instr_count)
    );

    always #5 i_clk = ~i_clk;

    // Offers the word for one edge; returns at the negedge of c1 (DECODE).
    task automatic issue(input logic [31:0] instr);
        @(negedge i_clk);
        i_instr_valid = 1'b1;
        i_instruction = instr;
        @(negedge i_clk);
        i_instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #2;
        total++;
        if ({strb, sels, o_illegal, o_retired} !== 11'd0) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=0", {strb, sels, o_illegal, o_retired});
        end
        total++;
        if ({o_AluControl, o_instr_count, o_first5bits, o_second5bits, o_immediate} !== {3'b010, 16'd0, 5'd0, 5'd0, 16'd0}) begin
            bad++;
            $display("FAIL reset_fields alu=%b cnt=%h f=%0d s=%0d imm=%h", o_AluControl, o_instr_count,
                     o_first5bits, o_second5bits, o_immediate);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        total++;
        if (o_instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", o_instr_ready);
        end
        exp_count = 16'd0;
    endtask

    task automatic test_add();
        issue(32'h00221820);
        // valid held with a junk word outside IDLE must be ignored
        i_instr_valid = 1'b1;
        i_instruction = 32'hFFFFFFFF;
        total++;
        if ({o_instr_ready, sels, strb} !== {1'b0, 6'b101000, 3'b000}) begin
            bad++;
            $display("FAIL add_c1 got rdy=%b sels=%b strb=%b", o_instr_ready, sels, strb);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        total++;
        if ({strb, sels, o_AluControl, o_retired} !== {3'b100, 6'b101000, 3'b010, 1'b1}) begin
            bad++;
            $display("FAIL add_c3 got strb=%b sels=%b alu=%b ret=%b", strb, sels, o_AluControl, o_retired);
        end
        total++;
        if ({o_first5bits, o_second5bits, o_immediate} !== {5'd1, 5'd2, 16'h1820}) begin
            bad++;
            $display("FAIL add_fields got f=%0d s=%0d imm=%h", o_first5bits, o_second5bits, o_immediate);
        end
        i_instr_valid = 1'b0;
        exp_count++;
        @(negedge i_clk);
        total++;
        if ({o_instr_ready, o_retired, strb, o_instr_count} !== {1'b1, 1'b0, 3'b000, exp_count}) begin
            bad++;
            $display("FAIL add_c4 got rdy=%b ret=%b strb=%b cnt=%h want cnt=%h", o_instr_ready, o_retired,
                     strb, o_instr_count, exp_count);
        end
    endtask

    task automatic test_lw();
        issue(32'h8C850008);
        @(negedge i_clk);
        @(negedge i_clk);
        total++;
        if ({strb, o_retired, o_instr_ready} !== {3'b001, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL lw_mem got strb=%b ret=%b rdy=%b", strb, o_retired, o_instr_ready);
        end
        @(negedge i_clk);
        total++;
        if ({strb, sels, o_retired, o_AluControl} !== {3'b101, 6'b010000, 1'b1, 3'b010}) begin
            bad++;
            $display("FAIL lw_wb got strb=%b sels=%b ret=%b alu=%b", strb, sels, o_retired, o_AluControl);
        end
        exp_count++;
        @(negedge i_clk);
        total++;
        if ({o_instr_ready, o_instr_count} !== {1'b1, exp_count}) begin
            bad++;
            $display("FAIL lw_done got rdy=%b cnt=%h want cnt=%h", o_instr_ready, o_instr_count, exp_count);
        end
    endtask

    task automatic test_sw();
        logic [2:0] seen = 3'b000;
        issue(32'hAC85000C);
        seen = seen | strb;
        @(negedge i_clk);
        seen = seen | strb;
        @(negedge i_clk);
        total++;
        if ({strb, sels, o_retired} !== {3'b010, 6'b010000, 1'b1}) begin
            bad++;
            $display("FAIL sw_mem got strb=%b sels=%b ret=%b", strb, sels, o_retired);
        end
        total++;
        if (seen !== 3'b000) begin
            bad++;
            $display("FAIL sw_early_strobe got=%b want=000", seen);
        end
        exp_count++;
        @(negedge i_clk);
        total++;
        if ({o_instr_ready, strb, o_instr_count} !== {1'b1, 3'b000, exp_count}) begin
            bad++;
            $display("FAIL sw_done got rdy=%b strb=%b cnt=%h want cnt=%h", o_instr_ready, strb, o_instr_count,
                     exp_count);
        end
    endtask

    task automatic test_rtype_ops();
        logic [5:0] fn [4] = '{6'h2A, 6'h22, 6'h24, 6'h25};
        logic [2:0] ac [4] = '{3'b111, 3'b110, 3'b000, 3'b001};
        for (int k = 0; k < 4; k++) begin
            issue({26'h0088A00, fn[k]});
            total++;
            if (o_AluControl !== ac[k]) begin
                bad++;
                $display("FAIL rtype_alu funct=%h got=%b want=%b", fn[k], o_AluControl, ac[k]);
            end
            @(negedge i_clk);
            @(negedge i_clk);
            exp_count++;
            @(negedge i_clk);
        end
        total++;
        if (o_instr_count !== exp_count) begin
            bad++;
            $display("FAIL rtype_count got=%h want=%h", o_instr_count, exp_count);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] words [2] = '{32'hFC000000, 32'h00221803};
        for (int k = 0; k < 2; k++) begin
            issue(words[k]);
            total++;
            if ({o_illegal, strb, sels, o_retired, o_AluControl} !== {1'b1, 3'b000, 6'd0, 1'b0, 3'b010}) begin
                bad++;
                $display("FAIL illegal_c1 word=%h got ill=%b strb=%b sels=%b ret=%b alu=%b", words[k],
                         o_illegal, strb, sels, o_retired, o_AluControl);
            end
            @(negedge i_clk);
            total++;
            if ({o_illegal, o_instr_ready, o_instr_count} !== {1'b0, 1'b1, exp_count}) begin
                bad++;
                $display("FAIL illegal_c2 word=%h got ill=%b rdy=%b cnt=%h want cnt=%h", words[k], o_illegal,
                         o_instr_ready, o_instr_count, exp_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(32'h8C850008);
        @(negedge i_clk);
        @(negedge i_clk);
        total++;
        if (o_ReadEnDataMemory !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre got re=%b want=1", o_ReadEnDataMemory);
        end
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({strb, sels, o_retired, o_instr_count} !== {3'b000, 6'd0, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL rstmid_clear got strb=%b sels=%b ret=%b cnt=%h", strb, sels, o_retired, o_instr_count);
        end
        @(posedge i_clk);
        #1;
        total++;
        if (strb !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_hold got strb=%b want=000", strb);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_count = 16'd0;
        @(negedge i_clk);
        total++;
        if ({o_instr_ready, strb, o_instr_count} !== {1'b1, 3'b000, 16'd0}) begin
            bad++;
            $display("FAIL rstmid_after got rdy=%b strb=%b cnt=%h", o_instr_ready, strb, o_instr_count);
        end
    endtask

    task automatic test_wrap();
        // Preload the counter at terminal count rather than spend 65535 retires.
        @(negedge i_clk);
        force dut.instr_count = 16'hFFFF;
        @(negedge i_clk);
        release dut.instr_count;
        @(negedge i_clk);
        total++;
        if (o_instr_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_preload got=%h want=ffff", o_instr_count);
        end
        issue(32'h2085000C);
        @(negedge i_clk);
        @(negedge i_clk);
        total++;
        if ({strb, sels, o_retired} !== {3'b100, 6'b011000, 1'b1}) begin
            bad++;
            $display("FAIL addi_wb got strb=%b sels=%b ret=%b", strb, sels, o_retired);
        end
        @(negedge i_clk);
        total++;
        if (o_instr_count !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_count got=%h want=0000", o_instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_rtype_ops();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
